// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : fifo_pkg                                                   |
// | Description : Shared constants and Gray-code helpers for the async FIFO  |
// |               pointer logic.                                             |
// |               FIFO_ADDRSIZE - default memory address width               |
// |               FIFO_PTR_W    - pointer width (address width + wrap bit)   |
// |               ptr_t         - pointer type of FIFO_PTR_W bits            |
// |               f_bin2gray / f_gray2bin - pointer code conversions         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 8;
    localparam int FIFO_PTR_W    = FIFO_ADDRSIZE + 1;

    typedef logic [FIFO_PTR_W-1:0] ptr_t;

    function automatic ptr_t f_bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    function automatic ptr_t f_gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[FIFO_PTR_W-1] = gray[FIFO_PTR_W-1];
        for (int i = FIFO_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gray2bin                                                   |
// | Description : Combinational Gray-to-binary converter of WIDTH bits.      |
// |               gray_i - Gray-coded input                                  |
// |               bin_o  - binary equivalent                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_PTR_W
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Reduction XOR of the upper slice keeps every bit a flat, independent
    // expression instead of a ripple chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule : gray2bin
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gray_ptr_sync                                              |
// | Description : One clock domain's pointer logic of an asynchronous FIFO.  |
// |               Holds the local binary/Gray pointer pair, synchronises the |
// |               remote Gray pointer and produces a registered full (write  |
// |               side) or empty (read side) flag plus a fill level.         |
// |   clk           - domain clock, rising edge                              |
// |   rst_n         - synchronous active-low reset                           |
// |   inc_i         - advance local pointer (write / read strobe)            |
// |   remote_gray_i - other domain's Gray pointer (asynchronous)             |
// |   addr_o        - binary memory address                                  |
// |   ptr_gray_o    - registered local Gray pointer to the remote domain     |
// |   flag_o        - full (IS_WRITE=1) or empty (IS_WRITE=0)                |
// |   level_o       - occupancy, 0 .. 2^ADDRSIZE                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gray_ptr_sync
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = FIFO_ADDRSIZE,
    parameter int SYNC_STAGES = 2,
    parameter bit IS_WRITE    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_i,
    input  logic [ADDRSIZE:0]   remote_gray_i,
    output logic [ADDRSIZE-1:0] addr_o,
    output logic [ADDRSIZE:0]   ptr_gray_o,
    output logic                flag_o,
    output logic [ADDRSIZE:0]   level_o
);

    localparam int c_PTR_W = ADDRSIZE + 1;

    logic [c_PTR_W-1:0] bin_q;
    logic [c_PTR_W-1:0] bin_d;
    logic [c_PTR_W-1:0] gray_q;
    logic [c_PTR_W-1:0] gray_d;
    logic [c_PTR_W-1:0] level_q;
    logic [c_PTR_W-1:0] level_d;
    logic               flag_q;
    logic               flag_d;
    logic               inc_ok;
    logic [c_PTR_W-1:0] rsync;
    logic [c_PTR_W-1:0] rbin;
    logic [c_PTR_W-1:0] sync_q [SYNC_STAGES];

    // Gating on the registered flag means a strobe arriving on the same edge
    // that releases the flag is still dropped; the flag can never open early.
    assign inc_ok = inc_i & ~flag_q;
    assign bin_d  = bin_q + {{ADDRSIZE{1'b0}}, inc_ok};
    assign gray_d = bin_d ^ (bin_d >> 1);

    assign rsync  = sync_q[SYNC_STAGES-1];

    gray2bin #(
        .WIDTH (c_PTR_W)
    ) u_gray2bin (
        .gray_i (rsync),
        .bin_o  (rbin)
    );

    if (IS_WRITE) begin : g_write
        // Full: local pointer one lap ahead of the remote one. In Gray code
        // that is the remote value with its two MSBs inverted.
        assign flag_d  = (gray_d == {~rsync[ADDRSIZE:ADDRSIZE-1], rsync[ADDRSIZE-2:0]});
        assign level_d = bin_d - rbin;
    end else begin : g_read
        assign flag_d  = (gray_d == rsync);
        assign level_d = rbin - bin_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            flag_q  <= ~IS_WRITE;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            flag_q  <= flag_d;
        end
    end

    // Pure flop chain: no logic between stages so metastability has a full
    // cycle to resolve at each step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= remote_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign addr_o     = bin_q[ADDRSIZE-1:0];
    assign ptr_gray_o = gray_q;
    assign flag_o     = flag_q;
    assign level_o    = level_q;

endmodule : gray_ptr_sync
`default_nettype wire

// File: tb/tb_gray_ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gray_ptr_sync                                           |
// | Description : Self-checking bench for gray_ptr_sync, one write-side and  |
// |               one read-side instance with ADDRSIZE=3, SYNC_STAGES=2.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_inc, r_inc;
    logic [3:0] w_rem, r_rem;
    logic [2:0] w_addr, r_addr;
    logic [3:0] w_gray, r_gray, w_level, r_level;
    logic       w_flag, r_flag;

    int checks = 0;
    int errors = 0;

    // Reference model: pointer counts as plain integers, the remote value
    // seen by the comparison is simply the input sampled two edges earlier.
    int m_bin   [2];
    int m_flag  [2];
    int m_level [2];
    int m_win   [2][2];

    always #5 clk = ~clk;

    gray_ptr_sync #(.ADDRSIZE(3), .SYNC_STAGES(2), .IS_WRITE(1'b1)) u_wr (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc_i         (w_inc),
        .remote_gray_i (w_rem),
        .addr_o        (w_addr),
        .ptr_gray_o    (w_gray),
        .flag_o        (w_flag),
        .level_o       (w_level)
    );

    gray_ptr_sync #(.ADDRSIZE(3), .SYNC_STAGES(2), .IS_WRITE(1'b0)) u_rd (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc_i         (r_inc),
        .remote_gray_i (r_rem),
        .addr_o        (r_addr),
        .ptr_gray_o    (r_gray),
        .flag_o        (r_flag),
        .level_o       (r_level)
    );

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int from_gray(input int g);
        int res = 0;
        for (int b = 0; b < 16; b++) if (to_gray(b) == g) res = b;
        return res;
    endfunction

    function automatic void model_edge(input int i, input bit rst, input bit inc, input int rem);
        int nb, rb;
        if (!rst) begin
            m_bin[i]    = 0;
            m_flag[i]   = (i == 1) ? 1 : 0;
            m_level[i]  = 0;
            m_win[i][0] = 0;
            m_win[i][1] = 0;
        end else begin
            nb = (m_bin[i] + ((inc && m_flag[i] == 0) ? 1 : 0)) % 16;
            rb = from_gray(m_win[i][0]);
            if (i == 0) begin
                m_level[i] = (nb - rb) & 15;
                m_flag[i]  = (m_level[i] == 8) ? 1 : 0;
            end else begin
                m_level[i] = (rb - nb) & 15;
                m_flag[i]  = (nb == rb) ? 1 : 0;
            end
            m_bin[i]    = nb;
            m_win[i][0] = m_win[i][1];
            m_win[i][1] = rem;
        end
    endfunction

    task automatic tick();
        bit rs = rst_n;
        bit wi = w_inc;
        bit ri = r_inc;
        int wr = int'(w_rem);
        int rr = int'(r_rem);
        @(posedge clk);
        #1;
        model_edge(0, rs, wi, wr);
        model_edge(1, rs, ri, rr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; w_inc = 1'b0; r_inc = 1'b0; w_rem = '0; r_rem = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; w_inc = 1'b1; r_inc = 1'b1; w_rem = 4'hF; r_rem = 4'hF;
        tick();
        tick();
        checks++; if (w_gray  !== 4'h0) begin errors++; $display("FAIL reset_w_gray: got %h want 0", w_gray); end
        checks++; if (w_addr  !== 3'h0) begin errors++; $display("FAIL reset_w_addr: got %h want 0", w_addr); end
        checks++; if (w_level !== 4'h0) begin errors++; $display("FAIL reset_w_level: got %h want 0", w_level); end
        checks++; if (w_flag  !== 1'b0) begin errors++; $display("FAIL reset_w_flag: got %b want 0", w_flag); end
        checks++; if (r_gray  !== 4'h0) begin errors++; $display("FAIL reset_r_gray: got %h want 0", r_gray); end
        checks++; if (r_addr  !== 3'h0) begin errors++; $display("FAIL reset_r_addr: got %h want 0", r_addr); end
        checks++; if (r_level !== 4'h0) begin errors++; $display("FAIL reset_r_level: got %h want 0", r_level); end
        checks++; if (r_flag  !== 1'b1) begin errors++; $display("FAIL reset_r_flag: got %b want 1", r_flag); end
        r_inc = 1'b0; w_inc = 1'b0;
    endtask

    task automatic test_fill_to_full();
        logic [3:0] seq [9] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hC};
        do_reset();
        w_rem = 4'h0; w_inc = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++; if (w_gray !== seq[k]) begin errors++; $display("FAIL fill_gray[%0d]: got %h want %h", k, w_gray, seq[k]); end
            if (k < 7) begin
                checks++; if (w_flag !== 1'b0) begin errors++; $display("FAIL fill_flag_early[%0d]: got %b want 0", k, w_flag); end
            end else begin
                checks++; if (w_flag !== 1'b1) begin errors++; $display("FAIL fill_flag[%0d]: got %b want 1", k, w_flag); end
                checks++; if (w_level !== 4'd8) begin errors++; $display("FAIL fill_level[%0d]: got %0d want 8", k, w_level); end
            end
        end
        w_inc = 1'b0;
    endtask

    task automatic test_empty_release();
        do_reset();
        r_rem = 4'h3;
        tick();
        tick();
        checks++; if (r_flag !== 1'b1) begin errors++; $display("FAIL empty_hold: got %b want 1", r_flag); end
        tick();
        checks++; if (r_flag !== 1'b0) begin errors++; $display("FAIL empty_release: got %b want 0", r_flag); end
        checks++; if (r_level !== 4'd2) begin errors++; $display("FAIL empty_level: got %0d want 2", r_level); end
        r_inc = 1'b1;
        tick();
        checks++; if (r_addr !== 3'd1) begin errors++; $display("FAIL empty_addr1: got %0d want 1", r_addr); end
        checks++; if (r_flag !== 1'b0) begin errors++; $display("FAIL empty_flag1: got %b want 0", r_flag); end
        tick();
        checks++; if (r_addr !== 3'd2) begin errors++; $display("FAIL empty_addr2: got %0d want 2", r_addr); end
        checks++; if (r_flag !== 1'b1) begin errors++; $display("FAIL empty_flag2: got %b want 1", r_flag); end
        checks++; if (r_level !== 4'd0) begin errors++; $display("FAIL empty_level2: got %0d want 0", r_level); end
        r_inc = 1'b0;
    endtask

    task automatic test_wrap();
        int         wraps = 0;
        int         gwraps = 0;
        bit         flag_seen = 1'b0;
        logic [2:0] prev_addr;
        logic [3:0] prev_gray;
        do_reset();
        prev_addr = w_addr;
        prev_gray = w_gray;
        w_inc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            w_rem = (k >= 4) ? 4'(to_gray(k - 4)) : 4'h0;
            tick();
            if (prev_addr == 3'd7 && w_addr == 3'd0) wraps++;
            if (prev_gray == 4'h8 && w_gray == 4'h0) gwraps++;
            if (w_flag) flag_seen = 1'b1;
            checks++; if (w_gray !== 4'(to_gray(m_bin[0]))) begin errors++; $display("FAIL wrap_gray[%0d]: got %h want %h", k, w_gray, to_gray(m_bin[0])); end
            prev_addr = w_addr;
            prev_gray = w_gray;
        end
        w_inc = 1'b0;
        checks++; if (wraps != 2) begin errors++; $display("FAIL wrap_addr_count: got %0d want 2", wraps); end
        checks++; if (gwraps != 1) begin errors++; $display("FAIL wrap_gray_msb: got %0d want 1", gwraps); end
        checks++; if (flag_seen) begin errors++; $display("FAIL wrap_flag: got 1 want 0"); end
        checks++; if (w_gray !== 4'h6) begin errors++; $display("FAIL wrap_final: got %h want 6", w_gray); end
    endtask

    task automatic test_full_release();
        do_reset();
        w_rem = 4'h0; w_inc = 1'b1;
        repeat (8) tick();
        checks++; if (w_flag !== 1'b1 || w_gray !== 4'hC) begin errors++; $display("FAIL frel_full: got flag %b gray %h want 1 C", w_flag, w_gray); end
        w_rem = 4'h1;
        tick();
        tick();
        checks++; if (w_flag !== 1'b1 || w_gray !== 4'hC) begin errors++; $display("FAIL frel_hold: got flag %b gray %h want 1 C", w_flag, w_gray); end
        tick();
        checks++; if (w_flag !== 1'b0 || w_gray !== 4'hC) begin errors++; $display("FAIL frel_clear: got flag %b gray %h want 0 C", w_flag, w_gray); end
        tick();
        checks++; if (w_gray !== 4'hD) begin errors++; $display("FAIL frel_advance: got %h want D", w_gray); end
        checks++; if (w_flag !== 1'b1) begin errors++; $display("FAIL frel_refull: got %b want 1", w_flag); end
        w_inc = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        w_rem = 4'h0; w_inc = 1'b1;
        repeat (5) tick();
        w_inc = 1'b0;
        checks++; if (w_gray !== 4'h7 || w_level !== 4'd5) begin errors++; $display("FAIL mid_pre: got gray %h level %0d want 7 5", w_gray, w_level); end
        rst_n = 1'b0; w_inc = 1'b1; w_rem = 4'hF;
        tick();
        checks++; if (w_gray !== 4'h0 || w_addr !== 3'h0 || w_level !== 4'h0 || w_flag !== 1'b0)
            begin errors++; $display("FAIL mid_reset: got gray %h addr %h level %h flag %b want all 0", w_gray, w_addr, w_level, w_flag); end
        rst_n = 1'b1; w_inc = 1'b0;
        tick();
        checks++; if (w_level !== 4'd0) begin errors++; $display("FAIL mid_sync1: got %0d want 0", w_level); end
        tick();
        checks++; if (w_level !== 4'd0) begin errors++; $display("FAIL mid_sync2: got %0d want 0", w_level); end
        tick();
        checks++; if (w_level !== 4'd6) begin errors++; $display("FAIL mid_sync3: got %0d want 6", w_level); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            w_inc = ($urandom_range(0, 3) != 0);
            r_inc = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) w_rem = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) r_rem = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (w_gray !== 4'(to_gray(m_bin[0])) || w_addr !== 3'(m_bin[0] % 8) ||
                w_flag !== 1'(m_flag[0]) || w_level !== 4'(m_level[0])) begin
                errors++;
                $display("FAIL rand_w[%0d]: got gray %h addr %h flag %b level %h want %h %h %b %h",
                         k, w_gray, w_addr, w_flag, w_level, to_gray(m_bin[0]), m_bin[0] % 8, m_flag[0], m_level[0]);
            end
            checks++;
            if (r_gray !== 4'(to_gray(m_bin[1])) || r_addr !== 3'(m_bin[1] % 8) ||
                r_flag !== 1'(m_flag[1]) || r_level !== 4'(m_level[1])) begin
                errors++;
                $display("FAIL rand_r[%0d]: got gray %h addr %h flag %b level %h want %h %h %b %h",
                         k, r_gray, r_addr, r_flag, r_level, to_gray(m_bin[1]), m_bin[1] % 8, m_flag[1], m_level[1]);
            end
        end
        rst_n = 1'b1; w_inc = 1'b0; r_inc = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; w_inc = 1'b0; r_inc = 1'b0; w_rem = '0; r_rem = '0;
        test_reset();
        test_fill_to_full();
        test_empty_release();
        test_wrap();
        test_full_release();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gray_ptr_sync
`default_nettype wire
